// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, LSB-first byte assembly.
// Optional even-parity check before stop bit when UART_RX_PARITY_EN is defined.
module uart_rx_deserializer #(
   parameter int BAUD_DIV  = 868,
   parameter int DATA_BITS = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   output logic                 framing_error,
   output logic                 parity_error,
   output logic                 busy
);
   localparam int CW = $clog2(BAUD_DIV);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_LD  = CW'(BAUD_DIV/2 - 1);
   localparam logic [CW-1:0] FULL_LD  = CW'(BAUD_DIV - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t               state, state_n;
   logic                 rx_meta, rs;
   logic [CW-1:0]        cnt, cnt_n;
   logic [IW-1:0]        bit_idx, bit_idx_n;
   logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
   logic                 dv_n, fe_n, tick;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad, par_bad_n, pe_q, pe_n;
`endif

   // Idle-high reset values keep a reset release from looking like a start bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rs      <= 1'b1;
      end else begin
         rx_meta <= rx;
         rs      <= rx_meta;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         data          <= '0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad       <= 1'b0;
         pe_q          <= 1'b0;
`endif
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         bit_idx       <= bit_idx_n;
         shreg         <= shreg_n;
         data          <= data_n;
         data_valid    <= dv_n;
         framing_error <= fe_n;
`ifdef UART_RX_PARITY_EN
         par_bad       <= par_bad_n;
         pe_q          <= pe_n;
`endif
      end
   end

   assign tick = (cnt == '0);

   always_comb begin
      state_n   = state;
      cnt_n     = tick ? cnt : cnt - CW'(1);
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      data_n    = data;
      dv_n      = 1'b0;
      fe_n      = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_n = par_bad;
      pe_n      = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (!rs) begin
               state_n = S_START;
               cnt_n   = HALF_LD;
            end
         end
         S_START: begin
            // Line back high at mid-start means a glitch, not a frame.
            if (tick) begin
               if (rs) begin
                  state_n = S_IDLE;
               end else begin
                  state_n   = S_DATA;
                  cnt_n     = FULL_LD;
                  bit_idx_n = '0;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shreg_n = {rs, shreg[DATA_BITS-1:1]};
               cnt_n   = FULL_LD;
               if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end else begin
                  bit_idx_n = bit_idx + IW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               par_bad_n = rs ^ (^shreg);
               cnt_n     = FULL_LD;
               state_n   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (rs) begin
                  state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad) begin
                     pe_n = 1'b1;
                  end else begin
                     data_n = shreg;
                     dv_n   = 1'b1;
                  end
`else
                  data_n = shreg;
                  dv_n   = 1'b1;
`endif
               end else begin
                  fe_n    = 1'b1;
                  state_n = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rs) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   assign parity_error = pe_q;
`else
   assign parity_error = 1'b0;
`endif
   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer (BAUD_DIV=16, DATA_BITS=8); pulses
// are matched against a queue of expected events filled as frames are sent.
module tb_uart_rx_deserializer;
   localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NBITS = 10 + PB;

   typedef struct packed {
      logic [2:0] kind;   // {data_valid, framing_error, parity_error}
      logic [7:0] d;
   } exp_t;

   logic       clock, reset_n, rx;
   logic [7:0] data;
   logic       data_valid, framing_error, parity_error, busy;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   exp_t e;

   uart_rx_deserializer #(.BAUD_DIV(BD), .DATA_BITS(8)) dut (
      .clock(clock), .reset_n(reset_n), .rx(rx), .data(data),
      .data_valid(data_valid), .framing_error(framing_error),
      .parity_error(parity_error), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d, input logic stop_b, input logic par_b);
      logic [10:0] f;
      if (PB != 0) f = {stop_b, par_b, d, 1'b0};
      else         f = {1'b1, stop_b, d, 1'b0};
      return f;
   endfunction

   // Caller sits just after a negedge; each bit is held for BD clocks.
   task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b);
      logic [10:0] f;
      f = frame(d, stop_b, par_b);
      for (int b = 0; b < NBITS; b++) begin
         rx = f[b];
         repeat (BD) @(negedge clock);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n && (data_valid || framing_error || parity_error)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {data_valid, framing_error, parity_error}, 3'b000);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", {data_valid, framing_error, parity_error}, e.kind);
            chk("pulse_data", data, e.d);
         end
      end
   end

   initial begin
      logic [10:0] f;
      rx      = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_data", data, 8'h00);
      chk("rst_dv", data_valid, 1'b0);
      chk("rst_fe", framing_error, 1'b0);
      chk("rst_pe", parity_error, 1'b0);
      chk("rst_busy", busy, 1'b0);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      // 0x55 with exact latency: start drive at N0, sync 2 clks, mid-stop
      // sample 8+9*16 clks later, pulse visible one clock after that.
      f = frame(8'h55, 1'b1, ^8'h55);
      exp_q.push_back('{3'b100, 8'h55});
      for (int i = 0; i < NBITS*BD + 16; i++) begin
         if (i == 154 + PB*BD) begin
            chk("lat_pre_dv", data_valid, 1'b0);
            chk("lat_pre_busy", busy, 1'b1);
         end
         if (i == 155 + PB*BD) begin
            chk("lat_dv", data_valid, 1'b1);
            chk("lat_busy", busy, 1'b0);
         end
         rx = (i < NBITS*BD) ? f[i/BD] : 1'b1;
         @(negedge clock);
      end

      // back-to-back frames, no idle gap
      exp_q.push_back('{3'b100, 8'hA5});
      exp_q.push_back('{3'b100, 8'h3C});
      send(8'hA5, 1'b1, ^8'hA5);
      send(8'h3C, 1'b1, ^8'h3C);
      rx = 1'b1;
      repeat (10) @(negedge clock);
      chk("b2b_drained", exp_q.size(), 0);

      // 4-clock glitch
      rx = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 4) rx = 1'b1;
         if (i == 6) chk("glitch_busy_hi", busy, 1'b1);
         if (i == 14) chk("glitch_busy_lo", busy, 1'b0);
         @(negedge clock);
      end

      // bad stop bit, then line held low: one framing pulse, data kept
      exp_q.push_back('{3'b010, 8'h3C});
      send(8'hF0, 1'b0, ^8'hF0);
      repeat (40) @(negedge clock);
      chk("break_busy", busy, 1'b1);
      chk("break_data", data, 8'h3C);
      chk("break_drained", exp_q.size(), 0);
      rx = 1'b1;
      repeat (6) @(negedge clock);
      chk("break_exit", busy, 1'b0);

      // reset mid-frame after bit 3 of 0x81
      f = frame(8'h81, 1'b1, ^8'h81);
      for (int b = 0; b < 5; b++) begin
         rx = f[b];
         repeat (BD) @(negedge clock);
      end
      chk("mid_busy", busy, 1'b1);
      rx      = 1'b1;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_data", data, 8'h00);
      chk("mid_rst_dv", data_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (20) @(negedge clock);
      exp_q.push_back('{3'b100, 8'h81});
      send(8'h81, 1'b1, ^8'h81);
      rx = 1'b1;
      repeat (10) @(negedge clock);
      chk("post_rst_data", data, 8'h81);

`ifdef UART_RX_PARITY_EN
      exp_q.push_back('{3'b001, 8'h81});
      send(8'h07, 1'b1, 1'b0);
      exp_q.push_back('{3'b100, 8'h07});
      send(8'h07, 1'b1, 1'b1);
      rx = 1'b1;
      repeat (10) @(negedge clock);
      chk("par_data", data, 8'h07);
`endif

      repeat (40) @(negedge clock);
      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
